// File: rtl/bvashr_ne_witness_checker.sv
// Bit-serial checker that tests whether (x >>> sh) != t for a Skolem-produced shift amount sh.
// Optional invertibility-condition flag ic_viol is enabled by defining BVASHR_NE_IC_CHECK_EN.
module bvashr_ne_witness_checker #(
    parameter int WIDTH = 8,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] t,
    input  logic [SHW-1:0]   sh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sat,
    output logic [WIDTH-1:0] shifted
`ifdef BVASHR_NE_IC_CHECK_EN
    ,
    output logic             ic_viol
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [31:0] MAX_SH = 32'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CMP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] t_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_load;
    logic             sat_reg;
    logic [WIDTH-1:0] shifted_reg;
    logic             out_valid_reg;
    logic             accept;
`ifdef BVASHR_NE_IC_CHECK_EN
    logic             ic_reg;
    logic             ic_viol_reg;
`endif

    assign in_ready  = rst_n && (state_reg == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign sat       = sat_reg;
    assign shifted   = shifted_reg;
`ifdef BVASHR_NE_IC_CHECK_EN
    assign ic_viol   = ic_viol_reg;
`endif

    // Any shift of WIDTH-1 or more already yields full sign fill, so clamp there.
    always_comb begin
        count_load = CW'(sh);
        if (32'(sh) >= MAX_SH) begin
            count_load = CW'(WIDTH - 1);
        end
    end

    // One-position arithmetic right shift: each bit takes its upper neighbour, MSB replicates.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign shift_next[gi] = shift_reg[gi+1];
        end
    endgenerate
    assign shift_next[WIDTH-1] = shift_reg[WIDTH-1];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (count_load != '0) ? SHIFT : CMP;
                end
            end
            SHIFT: begin
                if (count_reg == CW'(1)) begin
                    state_next = CMP;
                end
            end
            CMP: begin
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            t_reg         <= '0;
            count_reg     <= '0;
            sat_reg       <= 1'b0;
            shifted_reg   <= '0;
            out_valid_reg <= 1'b0;
`ifdef BVASHR_NE_IC_CHECK_EN
            ic_reg        <= 1'b0;
            ic_viol_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= x;
                        t_reg     <= t;
                        count_reg <= count_load;
`ifdef BVASHR_NE_IC_CHECK_EN
                        // No witness can exist when x and t are both all-zeros or both all-ones.
                        ic_reg    <= ~(((x == '0) && (t == '0)) ||
                                       ((x == '1) && (t == '1)));
`endif
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_next;
                    count_reg <= count_reg - CW'(1);
                end
                CMP: begin
                    sat_reg       <= (shift_reg != t_reg);
                    shifted_reg   <= shift_reg;
                    out_valid_reg <= 1'b1;
`ifdef BVASHR_NE_IC_CHECK_EN
                    ic_viol_reg   <= ic_reg & ~(shift_reg != t_reg);
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
